// File: rtl/mux8_rr_sched.sv
// Round-robin owner scheduler for a shared 8:1 single-bit mux.
// Grants one requester at a time, bounds contended hold time, and samples in[sel].
module mux8_rr_sched #(
  parameter int HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [7:0] in,
  output logic [2:0] sel,
  output logic [7:0] gnt,
  output logic       busy,
  output logic       y
);

  localparam int CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t        state;
  logic [2:0]    ptr;
  logic [CW-1:0] hold_cnt;

  logic [7:0] cand;
  logic       hold_last;
  logic       contend;
  logic       keep;
  logic [3:0] pick;

  // Returns {found, index}: first set bit of c scanning upward from p, wrapping mod 8.
  function automatic logic [3:0] rr_pick(input logic [7:0] c, input logic [2:0] p);
    logic [3:0] r;
    logic [2:0] idx;
    r = 4'd0;
    for (int k = 7; k >= 0; k--) begin
      idx = p + 3'(k);
      if (c[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  always_comb begin
    hold_last = (hold_cnt == HOLD_LAST);
    contend   = |(req & ~gnt);
    keep      = (state == S_GRANT) && req[sel] && !(hold_last && contend);
    cand      = (state == S_IDLE) ? req : (req & ~gnt);
    pick      = rr_pick(cand, ptr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      sel      <= 3'd0;
      gnt      <= 8'd0;
      busy     <= 1'b0;
      y        <= 1'b0;
      ptr      <= 3'd0;
      hold_cnt <= '0;
    end else begin
      // y samples the owner's data using the select that was valid before this edge.
      y <= busy ? in[sel] : 1'b0;
      if (keep) begin
        if (!hold_last) hold_cnt <= hold_cnt + 1'b1;
      end else if (pick[3]) begin
        state    <= S_GRANT;
        sel      <= pick[2:0];
        gnt      <= 8'd1 << pick[2:0];
        busy     <= 1'b1;
        hold_cnt <= '0;
        ptr      <= pick[2:0] + 3'd1;
      end else begin
        state <= S_IDLE;
        gnt   <= 8'd0;
        busy  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux8_rr_sched.sv
// Bench for mux8_rr_sched: directed scenarios plus random traffic against an
// owner/queue-level reference model of the round-robin rules.
module tb_mux8_rr_sched;

  localparam int HOLD = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] din;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       busy;
  logic       y;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: owner index (-1 when idle), cycles held so far.
  int   m_owner;
  int   m_sel;
  int   m_ptr;
  int   m_held;
  logic m_y;

  mux8_rr_sched #(.HOLD_MAX(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .in(din),
    .sel(sel), .gnt(gnt), .busy(busy), .y(y)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_first(input logic [7:0] c, input int p);
    for (int k = 0; k < 8; k++) begin
      if (c[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_grant(input int w);
    m_owner = w;
    m_sel   = w;
    m_held  = 1;
    m_ptr   = (w + 1) % 8;
  endtask

  task automatic model_step(input logic [7:0] r, input logic [7:0] d);
    logic [7:0] others;
    int w;
    m_y = (m_owner >= 0) ? d[m_sel] : 1'b0;
    if (m_owner < 0) begin
      w = rr_first(r, m_ptr);
      if (w >= 0) model_grant(w);
    end else begin
      others = r;
      others[m_owner] = 1'b0;
      if (r[m_owner] && !(m_held >= HOLD && others != 8'd0)) begin
        m_held++;
      end else begin
        w = rr_first(others, m_ptr);
        if (w >= 0) model_grant(w);
        else m_owner = -1;
      end
    end
  endtask

  task automatic compare_model(input string tag);
    logic [7:0] eg;
    eg = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
    check({tag, ".gnt"},  32'(gnt),  32'(eg));
    check({tag, ".sel"},  32'(sel),  32'(m_sel));
    check({tag, ".busy"}, 32'(busy), 32'(m_owner >= 0));
    check({tag, ".y"},    32'(y),    32'(m_y));
  endtask

  task automatic cycle(input string tag, input logic [7:0] r, input logic [7:0] d);
    req = r;
    din = d;
    model_step(r, d);
    @(posedge clk);
    #1;
    compare_model(tag);
  endtask

  // Asserts reset between edges and checks outputs clear without a clock edge.
  task automatic do_reset(input logic [7:0] r);
    req   = r;
    rst_n = 1'b0;
    #2;
    m_owner = -1; m_sel = 0; m_ptr = 0; m_held = 0; m_y = 1'b0;
    check("rst.gnt",  32'(gnt),  32'd0);
    check("rst.sel",  32'(sel),  32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.y",    32'(y),    32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] r;
    rst_n = 1'b1;
    req = 8'd0;
    din = 8'd0;
    #1;
    do_reset(8'hFF);

    // Idle after release with no requests
    for (int i = 0; i < 10; i++) cycle("idle", 8'h00, 8'hFF);

    // Single requester with data sampling
    cycle("single1", 8'h04, 8'b10100111);
    check("single.sel", 32'(sel), 32'd2);
    check("single.y0", 32'(y), 32'd0);
    cycle("single2", 8'h04, 8'b10100111);
    check("single.y1", 32'(y), 32'd1);
    cycle("single3", 8'h00, 8'b10100111);
    check("single.idle_sel", 32'(sel), 32'd2);
    check("single.idle_busy", 32'(busy), 32'd0);

    // Full contention: each owner holds exactly HOLD cycles
    @(negedge clk);
    do_reset(8'h00);
    for (int i = 0; i < 40; i++) begin
      cycle("full", 8'hFF, 8'h55);
      check("full.seq", 32'(sel), 32'((i / HOLD) % 8));
    end

    // Early release and skip, then pointer after granting 7
    @(negedge clk);
    do_reset(8'h00);
    cycle("skip1", 8'h84, 8'hF0);
    check("skip.sel2", 32'(sel), 32'd2);
    cycle("skip2", 8'h80, 8'hF0);
    check("skip.sel7", 32'(sel), 32'd7);
    check("skip.nogap", 32'(busy), 32'd1);
    cycle("skip3", 8'h00, 8'hF0);
    cycle("skip4", 8'h21, 8'hF0);
    check("skip.wrap", 32'(sel), 32'd0);

    // Pointer fairness after owner 5 releases
    @(negedge clk);
    do_reset(8'h00);
    cycle("fair1", 8'h20, 8'h00);
    cycle("fair2", 8'h00, 8'h00);
    cycle("fair3", 8'h21, 8'h00);
    check("fair.sel", 32'(sel), 32'd0);

    // Reset in the middle of a grant
    @(negedge clk);
    do_reset(8'h00);
    for (int i = 0; i < 3 * HOLD + 1; i++) cycle("mid", 8'hFF, 8'hAA);
    check("mid.sel3", 32'(sel), 32'd3);
    do_reset(8'hFF);
    cycle("mid.after", 8'hFF, 8'hAA);
    check("mid.first", 32'(sel), 32'd0);

    // Random traffic: mix sparse, dense and sticky request patterns
    r = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0: r = 8'($urandom);
        1: r = 8'($urandom) & 8'($urandom) & 8'($urandom);
        2: r = r ^ (8'd1 << $urandom_range(0, 7));
        default: ;
      endcase
      if ($urandom_range(0, 199) == 0) begin
        @(negedge clk);
        do_reset(r);
      end
      cycle("rand", r, 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
